// File: rtl/rshift_signed_mul_core_pkg.sv
// mul_pkg: shared FSM encoding and default operand width for the signed multiplier
package mul_pkg;
  localparam int DEF_N = 8;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;
endpackage

// File: rtl/rshift_signed_mul_core_if.sv
// rshift_signed_mul_core_if: request/result bundle between controller and multiplier
interface rshift_signed_mul_core_if
  import mul_pkg::*;
#(
  parameter int N = DEF_N
);
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*N-1:0] p;
  modport master (output start, a, b, input busy, done, p);
  modport slave  (input start, a, b, output busy, done, p);
endinterface

// File: rtl/rshift_signed_mul_core_iter_counter.sv
// iter_counter: iteration index for the shift-add sequence, flags the final iteration
module iter_counter
  import mul_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic last
);
  localparam int CW = $clog2(N) + 1;
  logic [CW-1:0] cnt_q;
  // count RUN cycles; one spare bit lets it reach N without wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else if (clear) cnt_q <= '0;
    else if (en) cnt_q <= cnt_q + 1'b1;
  end
  assign last = cnt_q == CW'(N - 1);
endmodule

// File: rtl/rshift_signed_mul_core.sv
// rshift_signed_mul_core: sequential two's-complement multiplier, one add/sub-and-shift per cycle
module rshift_signed_mul_core
  import mul_pkg::*;
#(
  parameter int N = DEF_N
) (
  input logic clk,
  input logic rst,
  rshift_signed_mul_core_if.slave bus
);
  state_t         state_q, state_d;
  logic [N:0]     a_q, a_d;
  logic [N-1:0]   q_q, q_d, m_q, m_d;
  logic [2*N-1:0] p_q, p_d;
  logic [N:0]     addend, sum;
  logic           accept, run, last;
  assign accept = bus.start && (state_q == IDLE || state_q == DONE);
  assign run    = state_q == RUN;
  assign bus.p  = p_q;
  iter_counter #(.N(N)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clear(accept),
    .en   (run),
    .last (last)
  );
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  // next state: start restarts from IDLE/DONE, RUN ends after the last iteration
  always_comb begin
    state_d = accept ? RUN : run ? (last ? DONE : RUN) : IDLE;
  end
  // status outputs decoded from state
  always_comb begin
    bus.busy = state_q == RUN;
    bus.done = state_q == DONE;
  end
  // iteration step: the sign-bit weight is negative, so the final partial product is subtracted
  always_comb begin
    addend = q_q[0] ? {m_q[N-1], m_q} : '0;
    sum    = last ? a_q - addend : a_q + addend;
    a_d    = a_q;
    q_d    = q_q;
    m_d    = m_q;
    p_d    = p_q;
    if (accept) begin
      a_d = '0;
      q_d = bus.b;
      m_d = bus.a;
    end else if (run) begin
      a_d = {sum[N], sum[N:1]};
      q_d = {sum[0], q_q[N-1:1]};
      if (last) p_d = {sum[N:0], q_q[N-1:1]};
    end
  end
  // datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      q_q <= '0;
      m_q <= '0;
      p_q <= '0;
    end else begin
      a_q <= a_d;
      q_q <= q_d;
      m_q <= m_d;
      p_q <= p_d;
    end
  end
endmodule

// File: tb/tb_rshift_signed_mul_core.sv
// tb_rshift_signed_mul_core: scoreboard bench for the sequential signed multiplier
module tb_rshift_signed_mul_core;
  import mul_pkg::*;
  localparam int N = 8;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  rshift_signed_mul_core_if #(.N(N)) u_if ();
  rshift_signed_mul_core #(.N(N)) dut (.clk(clk), .rst(rst), .bus(u_if));
  logic [2*N-1:0] exp_q[$];
  int n_vec = 0, n_err = 0, n_done = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // compare each result against the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst === 1'b0 && u_if.done === 1'b1) begin
      n_done++;
      if (exp_q.size() > 0) check("p", u_if.p, exp_q.pop_front());
      else check("unexpected_done", u_if.done, 0);
    end
  end
  task automatic launch(input logic signed [N-1:0] a, input logic signed [N-1:0] b, input bit push);
    logic signed [2*N-1:0] e;
    @(negedge clk);
    u_if.a = a;
    u_if.b = b;
    u_if.start = 1'b1;
    e = a * b;
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1 u_if.start = 1'b0;
  endtask
  task automatic wait_done(output int lat, output int bc);
    lat = 0;
    bc = 0;
    while (u_if.done !== 1'b1 && lat < 40) begin
      bc += int'(u_if.busy);
      @(posedge clk);
      #1 lat++;
    end
    if (lat >= 40) check("done_timeout", u_if.done, 1);
  endtask
  int lat, bc, d0;
  time t1, t2;
  initial begin
    u_if.start = 1'b0;
    u_if.a = '0;
    u_if.b = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", u_if.busy, 0);
    check("rst_done", u_if.done, 0);
    check("rst_p", u_if.p, 0);
    rst = 1'b0;
    launch(3, 5, 1);
    wait_done(lat, bc);
    check("latency", lat, N);
    check("busy_cycles", bc, N);
    launch(-3, 5, 1);
    wait_done(lat, bc);
    launch(7, -6, 1);
    wait_done(lat, bc);
    launch(-128, -128, 1);
    wait_done(lat, bc);
    check("latency_min", lat, N);
    launch(127, -128, 1);
    wait_done(lat, bc);
    repeat (2) @(posedge clk);
    d0 = n_done;
    launch(3, 5, 1);
    repeat (2) @(posedge clk);
    launch(1, 1, 0);
    wait_done(lat, bc);
    repeat (12) @(posedge clk);
    check("ignored_start_dones", n_done - d0, 1);
    launch(3, 5, 1);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", u_if.busy, 0);
    check("abort_done", u_if.done, 0);
    check("abort_p", u_if.p, 0);
    exp_q.delete();
    d0 = n_done;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("abort_no_done", n_done - d0, 0);
    launch(2, -2, 1);
    wait_done(lat, bc);
    check("post_reset_latency", lat, N);
    launch(5, -7, 1);
    wait_done(lat, bc);
    t1 = $time;
    launch(-9, 11, 1);
    check("b2b_busy", u_if.busy, 1);
    check("b2b_done_low", u_if.done, 0);
    wait_done(lat, bc);
    t2 = $time;
    check("b2b_gap", int'((t2 - t1) / 10), N + 1);
    repeat (3) @(posedge clk);
    check("scoreboard_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
